control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 24 ++
 rtl/control_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: handshake and control bus between the sequencer and the datapath
// master: sequencer side (samples run/IR_data_out/mem_ready, drives the selects, enables and memory requests)
// slave: datapath/memory side
interface control_sequencer_if;
  logic        run;
  logic [31:0] IR_data_out;
  logic        mem_ready;
  logic [31:0] i;
  logic [31:0] reg_enable;
  logic [5:0]  ALU_Sel;
  logic        read;
  logic        incPC;
  logic        mem_read;
  logic        mem_write;
  logic        halted;
  modport master (
    input  run, IR_data_out, mem_ready,
    output i, reg_enable, ALU_Sel, read, incPC, mem_read, mem_write, halted
  );
  modport slave (
    output run, IR_data_out, mem_ready,
    input  i, reg_enable, ALU_Sel, read, incPC, mem_read, mem_write, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/execute control unit for a 32-bit register datapath
// clk: rising-edge clock; clr: asynchronous active-low reset
// bus: run/IR_data_out/mem_ready in; i (bus source), reg_enable, ALU_Sel, read, incPC, mem_read, mem_write, halted out
module control_sequencer #(
  parameter logic [4:0] HALT_OP = 5'b11111
) (
  input logic                 clk,
  input logic                 clr,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {IDLE, F0, F1, F2, EX3, EX4, EX5, EX6, MEMW, HALT} state_t;
  state_t     state;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_halt, is_alu, is_md, is_ld, is_st;
  logic       unused_ir;
  assign op        = bus.IR_data_out[31:27];
  assign ra        = bus.IR_data_out[26:23];
  assign rb        = bus.IR_data_out[22:19];
  assign rc        = bus.IR_data_out[18:15];
  assign unused_ir = ^bus.IR_data_out[14:0];
  // HALT_OP is checked first so a parameter that aliases another opcode still halts
  assign is_halt = op == HALT_OP;
  assign is_alu  = !is_halt && op <= 5'd9;
  assign is_md   = is_alu && (op == 5'd8 || op == 5'd9);
  assign is_ld   = !is_halt && op == 5'd16;
  assign is_st   = !is_halt && op == 5'd17;
  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= IDLE;
    else
      case (state)
        IDLE:    state <= bus.run ? F0 : IDLE;
        F0:      state <= F1;
        F1:      state <= bus.mem_ready ? F2 : F1;
        F2:      state <= EX3;
        EX3:     state <= is_halt ? HALT : (is_alu || is_ld || is_st) ? EX4 : F0;
        EX4:     state <= is_st ? MEMW : (is_ld && !bus.mem_ready) ? EX4 : EX5;
        EX5:     state <= is_md ? EX6 : F0;
        EX6:     state <= F0;
        MEMW:    state <= bus.mem_ready ? F0 : MEMW;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
  // Outputs decode from state and IR only; the MDR load in memory waits follows mem_ready directly
  always_comb begin
    bus.i          = '0;
    bus.reg_enable = '0;
    bus.ALU_Sel    = '0;
    bus.read       = 1'b0;
    bus.incPC      = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.halted     = 1'b0;
    case (state)
      F0: begin
        bus.i          = 32'h0010_0000;
        bus.reg_enable = 32'h0080_0000;
        bus.incPC      = 1'b1;
      end
      F1: begin
        bus.mem_read   = 1'b1;
        bus.read       = 1'b1;
        bus.reg_enable = {9'd0, bus.mem_ready, 22'd0};
      end
      F2: begin
        bus.i          = 32'h0040_0000;
        bus.reg_enable = 32'h0020_0000;
      end
      EX3: begin
        bus.i          = (is_alu || is_ld || is_st) ? 32'd1 << rb : 32'd0;
        bus.reg_enable = is_alu ? 32'h0100_0000 : (is_ld || is_st) ? 32'h0080_0000 : 32'd0;
      end
      EX4: begin
        bus.i          = is_alu ? 32'd1 << rc : is_st ? 32'd1 << ra : 32'd0;
        bus.ALU_Sel    = is_alu ? {1'b0, op} : 6'd0;
        bus.reg_enable = is_alu ? (is_md ? 32'h000C_0000 : 32'h0008_0000)
                       : is_st ? 32'h0040_0000 : is_ld ? {9'd0, bus.mem_ready, 22'd0} : 32'd0;
        bus.mem_read   = is_ld;
        bus.read       = is_ld;
      end
      EX5: begin
        bus.i          = is_md ? 32'h0004_0000 : is_ld ? 32'h0040_0000 : 32'h0008_0000;
        bus.reg_enable = is_md ? 32'h0001_0000 : 32'd1 << ra;
      end
      EX6: begin
        bus.i          = 32'h0008_0000;
        bus.reg_enable = 32'h0002_0000;
      end
      MEMW:    bus.mem_write = 1'b1;
      HALT:    bus.halted    = 1'b1;
      default: ;
    endcase
  end
endmodule
